anc_input_sequencer: RTL
========================

Name: anc_input_sequencer

Overview:
Upstream stage of the ANC top. It gathers the independently-timed x (reference), e (error) and a (desired) sample streams into aligned sample triples. Each triple is queued in a small FIFO and presented to the controller through an in_valid/controller_ready handshake. It also double-buffers the LMS step size so that step changes take effect only at sample boundaries. Overruns and misalignment are reported to the host.

Parameters:
W, 16, sample and step-size width (signed)
DEPTH, 4, FIFO depth in triples (power of two)
AW, 2, log2(DEPTH)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
enable  in  1  capture enable; low stops new frame assembly
x_valid  in  1  single-cycle strobe, x_data valid
x_data  in  W  reference sample (signed)
e_valid  in  1  single-cycle strobe, e_data valid
e_data  in  W  error sample (signed)
a_valid  in  1  single-cycle strobe, a_data valid
a_data  in  W  desired sample (signed)
u_cfg  in  W  new LMS step size
u_cfg_load  in  1  load u_cfg into pending register
controller_ready  in  1  downstream controller can accept a triple
out_valid  out  1  triple available (drives controller in_valid)
x_out  out  W  queued x sample
e_out  out  W  queued e sample
a_out  out  W  queued a sample
u_out  out  W  active step size (drives controller u_in)
fifo_level  out  AW+1  triples currently queued, 0..DEPTH
overrun_cnt  out  8  dropped frames, saturating at 255
misalign  out  1  sticky: a channel arrived twice before its frame completed

Behaviour:
- Reset (async, rst=1): all outputs 0. Capture flags, FIFO pointers, overrun_cnt, misalign, u_pending and u_out all cleared. Takes effect mid-frame or mid-transfer; partial frames are discarded.
- Capture stage: one holding register plus one flag per channel.
  - A valid strobe writes the holding register and sets its flag.
- Frame complete in cycle C: each flag is either already set or its valid is high in C. Same-cycle arrival of any combination counts.
  - At the edge ending C: the triple (current data where valid, else the held value) is pushed and all flags clear.
- Duplicate arrival: a valid on a channel whose flag is set, in a cycle where the frame does not complete.
  - The holding register is overwritten (newest wins), misalign sets (sticky until rst), and the other flags are unaffected.
- enable=0: valids are ignored, flags clear at the next edge, no pushes. The FIFO continues to drain.
- FIFO, DEPTH entries, read/write pointers AW bits with wrap-around. fifo_level is registered.
  - pop = out_valid & controller_ready.
  - push is accepted if level<DEPTH, or if level==DEPTH and pop happens in the same cycle.
  - A rejected push drops the new triple; the queued triples are kept. overrun_cnt increments (saturating at 255).
  - Simultaneous accepted push and pop: level unchanged.
- Output side:
  - out_valid = (fifo_level != 0).
  - x_out/e_out/a_out show the head entry, stable while out_valid=1 and controller_ready=0.
  - When empty, the data outputs hold the last popped values (0 after reset).
- Latency: frame completes in cycle C with the FIFO empty → out_valid=1 and data visible in cycle C+1. Maximum throughput is one triple per cycle.
- Step size:
  - u_cfg_load writes u_pending and sets a pending flag.
  - u_out takes u_pending at the first pop edge on or after the load. With the FIFO empty, u_out waits for the next pop.
  - A load in the same cycle as a pop is transferred at that edge.
  - Multiple loads before a pop: the last load wins.
- No arithmetic is performed on sample data; widths pass through unchanged and sign is preserved.

Test Plan:
- Staggered arrival x=0x0100 @t0, e=0xFF00 @t2, a=0x0003 @t5, ready=1 → out_valid pulses at t6 with x_out=0x0100, e_out=0xFF00, a_out=0x0003; fifo_level returns to 0 at t7.
- All three valids in one cycle with data 1,2,3 → one triple (1,2,3) next cycle; misalign stays 0.
- e strobed 0x0011 then 0x0022 before x/a arrive → misalign=1; emitted e_out=0x0022.
- ready=0 while 6 frames complete → fifo_level=4, overrun_cnt=2, head is frame 1. Raising ready pops frames 1–4 in order, one per cycle.
- FIFO full with ready=1 and a frame completing in the same cycle → push accepted, fifo_level stays 4, overrun_cnt unchanged.
- u_cfg=0x0040 loaded, then rst asserted mid-frame → all outputs 0 asynchronously. After release, reload u_cfg=0x0040: u_out stays 0 until the first pop, then reads 0x0040.

Source files
------------

// File: rtl/anc_input_sequencer.sv
// Aligns independently-timed x/e/a sample strobes into triples, queues them in a
// small FIFO for the controller and double-buffers the LMS step size to sample boundaries.
module anc_input_sequencer #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 x_valid,
  input  logic signed [W-1:0]  x_data,
  input  logic                 e_valid,
  input  logic signed [W-1:0]  e_data,
  input  logic                 a_valid,
  input  logic signed [W-1:0]  a_data,
  input  logic signed [W-1:0]  u_cfg,
  input  logic                 u_cfg_load,
  input  logic                 controller_ready,
  output logic                 out_valid,
  output logic signed [W-1:0]  x_out,
  output logic signed [W-1:0]  e_out,
  output logic signed [W-1:0]  a_out,
  output logic signed [W-1:0]  u_out,
  output logic [AW:0]          fifo_level,
  output logic [7:0]           overrun_cnt,
  output logic                 misalign
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [W-1:0] hold_x, hold_e, hold_a;
  logic         flag_x, flag_e, flag_a;
  logic         complete, dup, pop, push, drop;
  logic [W-1:0] push_x, push_e, push_a;

  logic [W-1:0] mem_x [DEPTH];
  logic [W-1:0] mem_e [DEPTH];
  logic [W-1:0] mem_a [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [W-1:0] last_x, last_e, last_a;

  logic [W-1:0] u_pending;
  logic         u_pend;

  // A frame completes when every channel is either held or arriving this cycle.
  always_comb begin
    complete = enable & (flag_x | x_valid) & (flag_e | e_valid) & (flag_a | a_valid);
    dup      = enable & ~complete &
               ((x_valid & flag_x) | (e_valid & flag_e) | (a_valid & flag_a));
    push_x   = x_valid ? x_data : hold_x;
    push_e   = e_valid ? e_data : hold_e;
    push_a   = a_valid ? a_data : hold_a;
    out_valid = (fifo_level != '0);
    pop      = out_valid & controller_ready;
    push     = complete & ((fifo_level != FULL_LEVEL) | pop);
    drop     = complete & ~push;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_x   <= '0;
      hold_e   <= '0;
      hold_a   <= '0;
      flag_x   <= 1'b0;
      flag_e   <= 1'b0;
      flag_a   <= 1'b0;
      misalign <= 1'b0;
    end else if (!enable) begin
      flag_x <= 1'b0;
      flag_e <= 1'b0;
      flag_a <= 1'b0;
    end else begin
      if (x_valid) hold_x <= x_data;
      if (e_valid) hold_e <= e_data;
      if (a_valid) hold_a <= a_data;
      if (complete) begin
        flag_x <= 1'b0;
        flag_e <= 1'b0;
        flag_a <= 1'b0;
      end else begin
        flag_x <= flag_x | x_valid;
        flag_e <= flag_e | e_valid;
        flag_a <= flag_a | a_valid;
      end
      if (dup) misalign <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_x[wr_ptr] <= push_x;
      mem_e[wr_ptr] <= push_e;
      mem_a[wr_ptr] <= push_a;
    end
  end

  // When full, a push and pop in the same cycle share the head slot: the
  // old head is captured into last_* at the same edge it is overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_level  <= '0;
      overrun_cnt <= '0;
      last_x      <= '0;
      last_e      <= '0;
      last_a      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_x <= mem_x[rd_ptr];
        last_e <= mem_e[rd_ptr];
        last_a <= mem_a[rd_ptr];
      end
      if (push && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (pop && !push) fifo_level <= fifo_level - 1'b1;
      if (drop && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
    end
  end

  assign x_out = out_valid ? mem_x[rd_ptr] : last_x;
  assign e_out = out_valid ? mem_e[rd_ptr] : last_e;
  assign a_out = out_valid ? mem_a[rd_ptr] : last_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      u_pending <= '0;
      u_pend    <= 1'b0;
      u_out     <= '0;
    end else begin
      if (u_cfg_load) u_pending <= u_cfg;
      if (pop) begin
        u_pend <= 1'b0;
        if (u_cfg_load)  u_out <= u_cfg;
        else if (u_pend) u_out <= u_pending;
      end else if (u_cfg_load) begin
        u_pend <= 1'b1;
      end
    end
  end

endmodule
